// File: rtl/tx_sched_pkg.sv
// Shared types and helpers for the TX port read sequencer.
package tx_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT,
    RUN,
    GAP
  } schedState_t;

  localparam int C_RD_LATENCY_DEF = 5;

  // Word count to 128-bit beat count; callers pass a zero-extended length so the +3 cannot wrap.
  function automatic logic [63:0] calcBeats(input logic [63:0] lenWords);
    return (lenWords + 64'd3) >> 2;
  endfunction

endpackage

// File: rtl/tx_sched_delay.sv
// Fixed-depth shift pipe with async active-low clear; aligns RD_EN-side strobes with buffer read data.
module tx_sched_delay #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] dIn,
  output logic [WIDTH-1:0] dOut
);

  logic [WIDTH-1:0] stage_p [DEPTH];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) stage_p[i] <= '0;
    end else begin
      stage_p[0] <= dIn;
      for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
    end
  end

  assign dOut = stage_p[DEPTH-1];

endmodule

// File: rtl/tx_port_read_sched_128.sv
// Read sequencer for the 128-bit TX port buffer: one request at a time, one contiguous RD_EN run.
// Define TX_SCHED_STATS_EN to build the WAIT-cycle and accepted-request counters.
module tx_port_read_sched_128
  import tx_sched_pkg::*;
#(
  parameter int C_FIFO_DEPTH       = 512,
  parameter int C_FIFO_DEPTH_WIDTH = $clog2((2**$clog2(C_FIFO_DEPTH))+1),
  parameter int C_LEN_WIDTH        = 32,
  parameter int C_RD_LATENCY       = C_RD_LATENCY_DEF
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          REQ_VALID,
  output logic                          REQ_READY,
  input  logic [C_LEN_WIDTH-1:0]        REQ_LEN,
  input  logic                          REQ_LAST,
  input  logic                          ENG_RDY,
  input  logic [C_FIFO_DEPTH_WIDTH-1:0] WR_COUNT,
  output logic                          LEN_VALID,
  output logic [1:0]                    LEN_LSB,
  output logic                          LEN_LAST,
  output logic                          RD_EN,
  output logic                          DATA_VALID,
  output logic                          DATA_LAST,
  output logic                          DONE,
  output logic [31:0]                   STAT_STALL,
  output logic [31:0]                   STAT_REQS
);

  localparam int BEATS_W = C_LEN_WIDTH + 1;

  schedState_t        state, nextState;
  logic [BEATS_W-1:0] reqBeats, runCnt;
  logic [1:0]         reqLsb;
  logic               reqLast;
  logic               accept, resOk, lastBeat;
  logic [1:0]         pipeOut;

  assign accept   = REQ_VALID & REQ_READY;
  // Conservative: bytes already cached inside the buffer are not credited.
  assign resOk    = ENG_RDY && (64'(WR_COUNT) >= 64'(reqBeats));
  assign lastBeat = (state == RUN) && (runCnt == BEATS_W'(1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (accept) nextState = SETUP;
      SETUP: begin
        if (reqBeats == '0) nextState = IDLE;
        else if (resOk)     nextState = RUN;
        else                nextState = WAIT;
      end
      WAIT:    if (resOk) nextState = RUN;
      RUN:     if (runCnt == BEATS_W'(1)) nextState = GAP;
      GAP:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    REQ_READY = 1'b0;
    LEN_VALID = 1'b0;
    LEN_LSB   = 2'b00;
    LEN_LAST  = 1'b0;
    RD_EN     = 1'b0;
    unique case (state)
      IDLE:  REQ_READY = RST_N;
      SETUP: begin
        LEN_VALID = 1'b1;
        LEN_LSB   = reqLsb;
        LEN_LAST  = reqLast;
      end
      RUN:     RD_EN = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      reqBeats <= BEATS_W'(calcBeats(64'(REQ_LEN)));
      reqLsb   <= REQ_LEN[1:0];
      reqLast  <= REQ_LAST;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                                 runCnt <= '0;
    else if (nextState == RUN && state != RUN)  runCnt <= reqBeats;
    else if (state == RUN)                      runCnt <= runCnt - BEATS_W'(1);
  end

  // Read-latency alignment: {valid, last} emerge with the matching RD_DATA beat.
  tx_sched_delay #(
    .DEPTH (C_RD_LATENCY),
    .WIDTH (2)
  ) uDelay (
    .CLK   (CLK),
    .RST_N (RST_N),
    .dIn   ({RD_EN, lastBeat}),
    .dOut  (pipeOut)
  );

  assign DATA_VALID = pipeOut[1];
  assign DATA_LAST  = pipeOut[0];
  assign DONE       = (DATA_VALID & DATA_LAST) | ((state == SETUP) && (reqBeats == '0));

`ifdef TX_SCHED_STATS_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      STAT_STALL <= '0;
      STAT_REQS  <= '0;
    end else begin
      if (state == WAIT)                     STAT_STALL <= STAT_STALL + 32'd1;
      if (accept && (REQ_LEN != '0))        STAT_REQS  <= STAT_REQS + 32'd1;
    end
  end
`else
  assign STAT_STALL = '0;
  assign STAT_REQS  = '0;
`endif

endmodule

// File: tb/tb_tx_port_read_sched_128.sv
// Bench for tx_port_read_sched_128: directed and random requests against a timing-window reference model.
module tb_tx_port_read_sched_128;

  localparam int WCW = 10;
`ifdef TX_SCHED_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic           CLK = 1'b0;
  logic           RST_N = 1'b0;
  logic           REQ_VALID = 1'b0;
  logic [31:0]    REQ_LEN = '0;
  logic           REQ_LAST = 1'b0;
  logic           ENG_RDY = 1'b0;
  logic [WCW-1:0] WR_COUNT = '0;
  logic           REQ_READY, LEN_VALID, LEN_LAST, RD_EN, DATA_VALID, DATA_LAST, DONE;
  logic [1:0]     LEN_LSB;
  logic [31:0]    STAT_STALL, STAT_REQS;

  tx_port_read_sched_128 dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .REQ_VALID  (REQ_VALID),
    .REQ_READY  (REQ_READY),
    .REQ_LEN    (REQ_LEN),
    .REQ_LAST   (REQ_LAST),
    .ENG_RDY    (ENG_RDY),
    .WR_COUNT   (WR_COUNT),
    .LEN_VALID  (LEN_VALID),
    .LEN_LSB    (LEN_LSB),
    .LEN_LAST   (LEN_LAST),
    .RD_EN      (RD_EN),
    .DATA_VALID (DATA_VALID),
    .DATA_LAST  (DATA_LAST),
    .DONE       (DONE),
    .STAT_STALL (STAT_STALL),
    .STAT_REQS  (STAT_REQS)
  );

  always #5 CLK = ~CLK;

  // One accepted request: accept cycle t, first RD_EN cycle r, beat count b.
  typedef struct {
    int         t;
    int         r;
    int         b;
    logic [1:0] lsb;
    logic       last;
  } req_t;

  req_t reqs[$];
  int   cyc = 0;
  int   testsRun = 0;
  int   testsFailed = 0;
  int   expStall = 0;
  int   expReqs = 0;
  bit   inReset = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] statExp(input int v);
    return STATS_ON ? 32'(v) : 32'd0;
  endfunction

  task automatic checkCycle();
    logic       eRd = 1'b0, eDv = 1'b0, eDl = 1'b0, eDone = 1'b0, eLv = 1'b0, busy = 1'b0;
    logic [1:0] eLsb = 2'b00;
    logic       eLast = 1'b0;
    foreach (reqs[i]) begin
      if (cyc == reqs[i].t + 1) begin
        eLv = 1'b1; busy = 1'b1; eLsb = reqs[i].lsb; eLast = reqs[i].last;
      end
      if (reqs[i].b == 0) begin
        if (cyc == reqs[i].t + 1) eDone = 1'b1;
      end else begin
        if (cyc > reqs[i].t && cyc <= reqs[i].r + reqs[i].b) busy = 1'b1;
        if (cyc >= reqs[i].r && cyc < reqs[i].r + reqs[i].b) eRd = 1'b1;
        if (cyc >= reqs[i].r + 5 && cyc < reqs[i].r + reqs[i].b + 5) eDv = 1'b1;
        if (cyc == reqs[i].r + reqs[i].b + 4) begin eDl = 1'b1; eDone = 1'b1; end
      end
    end
    chk("req_ready", 32'(REQ_READY), 32'(!inReset && !busy));
    chk("len_valid", 32'(LEN_VALID), 32'(eLv));
    chk("rd_en", 32'(RD_EN), 32'(eRd));
    chk("data_valid", 32'(DATA_VALID), 32'(eDv));
    chk("data_last", 32'(DATA_LAST), 32'(eDl));
    chk("done", 32'(DONE), 32'(eDone));
    if (eLv) begin
      chk("len_lsb", 32'(LEN_LSB), 32'(eLsb));
      chk("len_last", 32'(LEN_LAST), 32'(eLast));
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    checkCycle();
  endtask

  // Resources either satisfy the beat count (avail) or deliberately fall short of it.
  task automatic setRes(input int b, input bit avail, input int wcLo, input int wcHi);
    if (avail) begin
      WR_COUNT = (wcHi >= 0) ? WCW'(wcHi) : WCW'(b + int'($urandom_range(0, 3)));
      ENG_RDY  = 1'b1;
    end else if (wcLo >= 0) begin
      WR_COUNT = WCW'(wcLo);
      ENG_RDY  = 1'b1;
    end else if ($urandom_range(0, 1) == 1) begin
      WR_COUNT = WCW'($urandom_range(0, b - 1));
      ENG_RDY  = 1'($urandom);
    end else begin
      WR_COUNT = WCW'(b + int'($urandom_range(0, 5)));
      ENG_RDY  = 1'b0;
    end
  endtask

  // Issue one request; resources are withheld for k cycles after acceptance.
  task automatic doReq(input int len, input bit last, input int k, input int wcLo, input int wcHi);
    int   b = (len + 3) / 4;
    int   n = 0;
    req_t e;
    while (REQ_READY !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("ready_wait_timeout", 32'(REQ_READY), 32'd1);
    REQ_VALID = 1'b1;
    REQ_LEN   = 32'(len);
    REQ_LAST  = last;
    setRes(b, (k == 0) || (b == 0), wcLo, wcHi);
    e.t = cyc; e.r = cyc + 2 + k; e.b = b; e.lsb = 2'(len); e.last = last;
    reqs.push_back(e);
    if (b != 0) begin
      expReqs++;
      expStall += k;
    end
    tick();
    REQ_VALID = 1'b0;
    REQ_LEN   = $urandom;
    REQ_LAST  = 1'($urandom);
    if (b != 0 && k > 0) begin
      repeat (k) tick();
      setRes(b, 1'b1, wcLo, wcHi);
    end
  endtask

  task automatic randomBurst(input int count);
    for (int i = 0; i < count; i++) begin
      int len = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 48));
      int k   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      doReq(len, 1'($urandom), k, -1, -1);
      tick();
      WR_COUNT = WCW'($urandom);
      ENG_RDY  = 1'($urandom);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    #1;
    checkCycle();
    repeat (2) tick();
    RST_N   = 1'b1;
    inReset = 1'b0;
    tick();

    doReq(8, 1'b0, 0, -1, 10);
    repeat (10) tick();
    doReq(5, 1'b1, 0, -1, -1);
    repeat (10) tick();
    doReq(16, 1'b0, 20, 2, 4);
    repeat (10) tick();
    chk("stat_stall_len16", STAT_STALL, statExp(expStall));
    doReq(0, 1'b0, 0, -1, -1);
    repeat (4) tick();
    doReq(4, 1'b0, 0, -1, 4);
    doReq(4, 1'b1, 0, -1, 4);
    repeat (10) tick();
    chk("stat_reqs_directed", STAT_REQS, statExp(expReqs));

    randomBurst(40);
    repeat (12) tick();
    chk("stat_stall_random", STAT_STALL, statExp(expStall));
    chk("stat_reqs_random", STAT_REQS, statExp(expReqs));

    // Reset lands in the third cycle of a 10-beat run.
    doReq(40, 1'b0, 0, -1, -1);
    repeat (3) tick();
    #2;
    RST_N = 1'b0;
    #1;
    chk("rst_async_rd_en", 32'(RD_EN), 32'd0);
    chk("rst_async_data_valid", 32'(DATA_VALID), 32'd0);
    chk("rst_async_done", 32'(DONE), 32'd0);
    chk("rst_async_req_ready", 32'(REQ_READY), 32'd0);
    inReset = 1'b1;
    reqs.delete();
    expStall = 0;
    expReqs  = 0;
    tick();
    RST_N   = 1'b1;
    inReset = 1'b0;
    repeat (12) tick();
    chk("stat_stall_after_rst", STAT_STALL, statExp(0));
    chk("stat_reqs_after_rst", STAT_REQS, statExp(0));

    randomBurst(6);
    repeat (12) tick();
    chk("stat_stall_final", STAT_STALL, statExp(expStall));
    chk("stat_reqs_final", STAT_REQS, statExp(expReqs));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
